// File: rtl/lsu_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_pkg
// Shared definitions for the load/store unit:
//   - funct3 width/sign encodings
//   - FSM state codes (IDLE, REQ, WAIT, DONE)
//   - helpers for lane offset, byte enables, store replication, misalignment
// ---------------------------------------------------------------------------
package lsu_mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // Lane offset actually used on the bus: halfword and word accesses
    // have their offending low bits forced to zero.
    function automatic logic [1:0] access_offset(input logic [2:0] f3,
                                                 input logic [1:0] lo);
        logic [1:0] off;
        case (f3)
            F3_H, F3_HU: off = {lo[1], 1'b0};
            F3_W:        off = 2'b00;
            default:     off = lo;
        endcase
        return off;
    endfunction

    // True when the raw address is not naturally aligned for the width.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << off;
            F3_H, F3_HU: be = 4'b0011 << {off[1], 1'b0};
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store datum across all lanes; byte enables pick the lane.
    function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                                input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            F3_W:    w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Word-wide data-memory bus with req/gnt/rvalid handshake.
//   req/we/addr/be/wdata : LSU -> memory
//   gnt/rvalid/rdata     : memory -> LSU
// Modports: master (LSU side), slave (memory side).
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl_load_align.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_load_align (combinational)
// Selects the addressed lane of a read word and sign/zero-extends it.
//   rdata  : raw word from memory
//   off    : byte offset of the access within the word
//   funct3 : width/sign selector
//   data   : extended load result (0 for an unknown funct3)
// ---------------------------------------------------------------------------
module lsu_mem_ctrl_load_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    // Move the addressed lane down to bit 0, then extend by width/sign.
    always_comb begin
        shifted_s = rdata >> {off, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   data = {24'h00_0000, shifted_s[7:0]};
            F3_H:    data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   data = {16'h0000, shifted_s[15:0]};
            F3_W:    data = shifted_s;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store unit: turns LSU commands into data-memory bus transactions,
// aligns store data into byte lanes, extends load data and stalls the core
// until the access finishes.
//
// Ports
//   clk, rst        : core clock; asynchronous active-high reset
//   en              : load/store instruction in execute
//   mem_read        : load command
//   mem_write       : store command (wins over mem_read)
//   funct3          : 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr            : effective byte address
//   store_data      : rs2 value
//   mem             : memory bus (master modport)
//   stall           : hold PC/pipeline
//   load_valid      : one-cycle pulse, load result valid
//   load_data       : extended load result
//   fault           : one-cycle pulse: illegal funct3, misaligned, timeout
//
// Parameter
//   TIMEOUT_CYCLES  : cycles allowed in REQ+WAIT before a bus fault (1..255)
//
// Build option
//   LSU_MISALIGN_TRAP_EN : misaligned H/W accesses fault without a bus
//   access. When undefined the offending low address bits are cleared
//   and the access proceeds without a fault.
// ---------------------------------------------------------------------------
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [31:0]          addr,
    input  logic [31:0]          store_data,
    lsu_mem_ctrl_if.master       mem,
    output logic                 stall,
    output logic                 load_valid,
    output logic [31:0]          load_data,
    output logic                 fault
);

    // Counter value on the last permitted REQ/WAIT cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_r;
    logic [7:0]  cnt_r;
    logic        req_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic        is_load_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic        load_valid_r;
    logic [31:0] load_data_r;
    logic        fault_r;

    logic        start_s;
    logic        legal_s;
    logic        reject_s;
    logic [1:0]  off_s;
    logic        timeout_s;
    logic [31:0] aligned_s;

    // Decode the incoming command: legality, lane offset and reject reason.
    always_comb begin
        start_s = en & (mem_read | mem_write);
        case (funct3)
            F3_B, F3_H, F3_W: legal_s = 1'b1;
            F3_BU, F3_HU:     legal_s = ~mem_write;   // no unsigned stores
            default:          legal_s = 1'b0;
        endcase
        off_s = access_offset(funct3, addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        reject_s = ~legal_s | misaligned(funct3, addr[1:0]);
`else
        reject_s = ~legal_s;
`endif
        timeout_s = (cnt_r == TIMEOUT_LAST);
    end

    // The core must hold from the cycle a command is seen until DONE.
    always_comb begin
        stall = ((state_r == ST_IDLE) & start_s) |
                (state_r == ST_REQ) | (state_r == ST_WAIT);
    end

    lsu_mem_ctrl_load_align u_load_align (
        .rdata  (mem.rdata),
        .off    (off_r),
        .funct3 (f3_r),
        .data   (aligned_s)
    );

    // Access FSM, timeout counter, latched bus fields and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            be_r         <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
            is_load_r    <= 1'b0;
            f3_r         <= 3'b000;
            off_r        <= 2'b00;
            load_valid_r <= 1'b0;
            load_data_r  <= 32'h0000_0000;
            fault_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 8'd0;
                    if (start_s) begin
                        if (reject_s) begin
                            state_r     <= ST_DONE;
                            fault_r     <= 1'b1;
                            load_data_r <= 32'h0000_0000;
                        end else begin
                            state_r   <= ST_REQ;
                            req_r     <= 1'b1;
                            we_r      <= mem_write;
                            is_load_r <= ~mem_write;
                            f3_r      <= funct3;
                            off_r     <= off_s;
                            addr_r    <= {addr[31:2], 2'b00};
                            be_r      <= byte_enable(funct3, off_s);
                            wdata_r   <= mem_write ? store_lanes(funct3, store_data)
                                                   : 32'h0000_0000;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (mem.gnt) begin
                        req_r <= 1'b0;
                        if (!is_load_r) begin
                            state_r <= ST_DONE;
                        end else if (mem.rvalid) begin
                            state_r      <= ST_DONE;
                            load_valid_r <= 1'b1;
                            load_data_r  <= aligned_s;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else if (timeout_s) begin
                        state_r     <= ST_DONE;
                        req_r       <= 1'b0;
                        fault_r     <= 1'b1;
                        load_data_r <= 32'h0000_0000;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (mem.rvalid) begin
                        state_r      <= ST_DONE;
                        load_valid_r <= 1'b1;
                        load_data_r  <= aligned_s;
                    end else if (timeout_s) begin
                        state_r     <= ST_DONE;
                        fault_r     <= 1'b1;
                        load_data_r <= 32'h0000_0000;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    load_valid_r <= 1'b0;
                    fault_r      <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_r        <= 1'b0;
                    load_valid_r <= 1'b0;
                    fault_r      <= 1'b0;
                end
            endcase
        end
    end

    assign mem.req    = req_r;
    assign mem.we     = we_r;
    assign mem.addr   = addr_r;
    assign mem.be     = be_r;
    assign mem.wdata  = wdata_r;
    assign load_valid = load_valid_r;
    assign load_data  = load_data_r;
    assign fault      = fault_r;

endmodule
